ram_read_arbiter: RTL and testbench
===================================

// Module: ram_read_arbiter
// PURPOSE
//  Shares one synchronous single-read-port RAM between N_REQ requesters. Picks one request per
//  cycle (round-robin) and drives the RAM read enable/address. Tracks requester ID through the
//  fixed RAM read latency and returns the read data to the requester that issued the read.
//  Sits between requester blocks and the RAM read-data capture stage.
// PARAMETERS
//  N_REQ      4   number of requesters (2..16)
//  ADDR_W     8   RAM address width
//  SIZE_DATA  8   RAM data width
//  RD_LAT     2   cycles from o_ram_rd_en sampled high to i_ram_rd_data valid (>=1)
// PORTS
//  i_clk          in   1               clock, rising edge
//  i_rst_n        in   1               asynchronous reset, active low
//  i_req          in   N_REQ           per-requester read request, held until granted
//  i_addr         in   N_REQ*ADDR_W    packed addresses; slice k belongs to i_req[k]
//  i_stall        in   1               1 = issue no new grants; in-flight reads still complete
//  o_gnt          out  N_REQ           one-hot grant, combinational, same cycle as the accepted i_req
//  o_ram_rd_en    out  1               registered RAM read enable
//  o_ram_addr     out  ADDR_W          registered RAM address
//  i_ram_rd_data  in   SIZE_DATA       RAM read data, valid RD_LAT cycles after o_ram_rd_en
//  o_rsp_valid    out  N_REQ           one-hot response strobe, 1 cycle
//  o_rsp_id       out  $clog2(N_REQ)   index of the requester that owns o_rsp_data
//  o_rsp_data     out  SIZE_DATA       response data; holds the last value between strobes
// BEHAVIOUR
//  - Reset values: o_ram_rd_en=0, o_ram_addr=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0,
//    rr pointer=0, in-flight pipe cleared. o_gnt=0 while i_rst_n=0.
//  - Grant: if i_stall=0 and |i_req, grant the first set request at index >= ptr, wrapping
//    N_REQ-1 -> 0. At most one grant per cycle. Request k is accepted when i_req[k]&o_gnt[k].
//  - Pointer: after a grant to k, ptr <= (k==N_REQ-1) ? 0 : k+1. No grant -> ptr unchanged.
//  - Issue (cycle t = grant): at t+1, o_ram_rd_en=1 and o_ram_addr=i_addr[k]. Without a grant,
//    o_ram_rd_en=0 and o_ram_addr holds its value.
//  - Tracking: {valid,id} shift pipe of depth RD_LAT+1, loaded at issue.
//  - Response: o_rsp_valid[k]=1, o_rsp_id=k and o_rsp_data=i_ram_rd_data (registered) at
//    t+2+RD_LAT, which is t+4 at default. Back-to-back grants give back-to-back responses
//    in grant order. When o_rsp_valid=0, o_rsp_data and o_rsp_id hold their last value.
//  - Throughput: 1 read/cycle sustained. No backpressure on responses; requesters must accept.
//  - i_stall: takes effect the same cycle (o_gnt=0). A pending request stays pending and is
//    not lost. Pointer frozen.
//  - Single requester continuously requesting: granted every cycle.
//  - Reset mid-operation: all in-flight reads are dropped, no o_rsp_valid after deassertion.
//  - A request deasserted before grant is simply not served. Address is sampled only at grant.
// CONFIGURATION
//  RAM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, no rr pointer.
//    Starvation of high indices is allowed.
//  Not defined (default): round-robin as above.
// STRUCTURE
//  ram_arb_pkg: localparam function id_w(n)=$clog2(n) (min 1);
//    typedef struct packed {logic vld; logic [id_w-1:0] id;} inflight_t.
//  Sub-module ram_arb_picker: combinational one-hot pick of req[] given ptr.
//    Selects fixed-priority vs round-robin under the macro.
//  Top level: ptr register, issue register, inflight_t pipe, response register.
// TESTING
//  1 Single read: i_req=0001, addr0=0x12, RAM returns 0xA5 -> o_gnt=0001 at t;
//    o_ram_rd_en/addr=0x12 at t+1; o_rsp_valid=0001, o_rsp_data=0xA5 at t+4.
//  2 All four requesting continuously from reset -> grant order 0,1,2,3,0,...;
//    responses in the same order, 1/cycle. With RAM_ARB_FIXED_PRIO_EN: grant always 0.
//  3 Wrap: ptr=3, i_req=1001 -> grant 3 then 0, ptr returns to 1.
//  4 i_stall=1 for 3 cycles with i_req=0100 -> o_gnt=0 and o_ram_rd_en=0 during stall;
//    grant on the first cycle with stall=0. In-flight responses issued before the stall still arrive.
//  5 Assert i_rst_n=0 at t+2 after a grant -> no o_rsp_valid after release; outputs at reset values.
//  6 Idle after a response of 0x3C -> o_rsp_data stays 0x3C and o_rsp_valid=0
//    while i_ram_rd_data toggles.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM read arbiter: requester-ID width and
// the {valid,id} record that follows each read through the RAM latency.
package ram_arb_pkg;

  localparam int N_REQ_MAX = 16;

  // Requester-ID width; a single bit is kept even for two requesters.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_MAX = id_w(N_REQ_MAX);

  // Sized for the largest supported N_REQ; narrower builds zero-extend the ID.
  typedef struct packed {
    logic                vld;
    logic [ID_W_MAX-1:0] id;
  } inflight_t;

endpackage

// File: rtl/ram_read_arbiter_if.sv
// Bundle of requester, RAM-side and response signals around ram_read_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface ram_read_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 8,
  parameter int SIZE_DATA = 8
);
  localparam int IW = ram_arb_pkg::id_w(N_REQ);

  logic [N_REQ-1:0]        i_req;
  logic [N_REQ*ADDR_W-1:0] i_addr;
  logic                    i_stall;
  logic [N_REQ-1:0]        o_gnt;
  logic                    o_ram_rd_en;
  logic [ADDR_W-1:0]       o_ram_addr;
  logic [SIZE_DATA-1:0]    i_ram_rd_data;
  logic [N_REQ-1:0]        o_rsp_valid;
  logic [IW-1:0]           o_rsp_id;
  logic [SIZE_DATA-1:0]    o_rsp_data;

  modport slave (
    input  i_req, i_addr, i_stall, i_ram_rd_data,
    output o_gnt, o_ram_rd_en, o_ram_addr, o_rsp_valid, o_rsp_id, o_rsp_data
  );

  modport master (
    output i_req, i_addr, i_stall, i_ram_rd_data,
    input  o_gnt, o_ram_rd_en, o_ram_addr, o_rsp_valid, o_rsp_id, o_rsp_data
  );

endinterface

// File: rtl/ram_arb_picker.sv
// Combinational one-hot pick of a request vector. Round-robin from ptr by default;
// RAM_ARB_FIXED_PRIO_EN switches to fixed priority (lowest index wins, no ptr port).
module ram_arb_picker
  import ram_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW   = id_w(N_REQ)
) (
`ifndef RAM_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]    ptr,
`endif
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN

  // Isolate the lowest set bit.
  assign gnt = req & (~req + N_REQ'(1));

`else

  logic [N_REQ-1:0] below_ptr;
  logic [N_REQ-1:0] upper_req;
  logic [N_REQ-1:0] cand;

  // Requests at or above ptr take precedence; otherwise wrap to the lowest index.
  assign below_ptr = (N_REQ'(1) << ptr) - N_REQ'(1);
  assign upper_req = req & ~below_ptr;
  assign cand      = (|upper_req) ? upper_req : req;
  assign gnt       = cand & (~cand + N_REQ'(1));

`endif

endmodule

// File: rtl/ram_read_arbiter.sv
// Round-robin read arbiter sharing one single-read-port RAM among N_REQ requesters,
// routing read data back by requester ID. Define RAM_ARB_FIXED_PRIO_EN for fixed priority.
module ram_read_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 8,
  parameter int SIZE_DATA = 8,
  parameter int RD_LAT    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  ram_read_arbiter_if.slave bus
);

  localparam int IW = id_w(N_REQ);

  logic [N_REQ-1:0]  pick;
  logic [N_REQ-1:0]  gnt;
  logic              any_gnt;
  logic [IW-1:0]     gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;

  logic [ADDR_W-1:0] addr_p0;
  inflight_t         inflight_p [RD_LAT+1];

  logic [N_REQ-1:0]     rsp_vld_p1;
  logic [IW-1:0]        rsp_id_p1;
  logic [SIZE_DATA-1:0] rsp_data_p1;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic [IW-1:0] ptr_q;
`endif

  ram_arb_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
`ifndef RAM_ARB_FIXED_PRIO_EN
    .ptr (ptr_q),
`endif
    .req (bus.i_req),
    .gnt (pick)
  );

  // Grant is combinational; stall and reset both suppress it in the same cycle.
  assign gnt       = (bus.i_stall || !i_rst_n) ? '0 : pick;
  assign any_gnt   = |gnt;
  assign bus.o_gnt = gnt;

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        gnt_idx  = IW'(k);
        gnt_addr = bus.i_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

`ifndef RAM_ARB_FIXED_PRIO_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (any_gnt) begin
      ptr_q <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end
`endif

  // ---- p0: issue to RAM; stage 0 of the in-flight pipe doubles as the read enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_p0 <= '0;
    end else if (any_gnt) begin
      addr_p0 <= gnt_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s <= RD_LAT; s++) begin
        inflight_p[s] <= '0;
      end
    end else begin
      inflight_p[0].vld <= any_gnt;
      inflight_p[0].id  <= ID_W_MAX'(gnt_idx);
      for (int s = 1; s <= RD_LAT; s++) begin
        inflight_p[s] <= inflight_p[s-1];
      end
    end
  end

  assign bus.o_ram_rd_en = inflight_p[0].vld;
  assign bus.o_ram_addr  = addr_p0;

  // ---- p1: capture RAM data for the owning requester; ID/data hold between strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_vld_p1  <= '0;
      rsp_id_p1   <= '0;
      rsp_data_p1 <= '0;
    end else if (inflight_p[RD_LAT].vld) begin
      rsp_vld_p1  <= N_REQ'(1) << inflight_p[RD_LAT].id;
      rsp_id_p1   <= IW'(inflight_p[RD_LAT].id);
      rsp_data_p1 <= bus.i_ram_rd_data;
    end else begin
      rsp_vld_p1  <= '0;
    end
  end

  assign bus.o_rsp_valid = rsp_vld_p1;
  assign bus.o_rsp_id    = rsp_id_p1;
  assign bus.o_rsp_data  = rsp_data_p1;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Scoreboard bench for ram_read_arbiter: a behavioural arbiter model queues expected
// RAM issues and responses at grant time; a negedge monitor pops and compares them.
module tb_ram_read_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int RDL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_read_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .SIZE_DATA(DW)) bus ();

  ram_read_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .SIZE_DATA(DW), .RD_LAT(RDL)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // RAM: RD_LAT register stages after sampling the read enable; garbage when idle.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ram_pipe [RDL];

  always @(posedge clk) begin
    ram_pipe[0] <= bus.o_ram_rd_en ? mem[bus.o_ram_addr] : DW'($urandom);
    for (int s = 1; s < RDL; s++) ram_pipe[s] <= ram_pipe[s-1];
  end
  assign bus.i_ram_rd_data = ram_pipe[RDL-1];

  typedef struct { int id; logic [DW-1:0] data; int due; } rsp_t;
  typedef struct { logic [AW-1:0] addr; int due; } iss_t;

  rsp_t rsp_q [$];
  iss_t iss_q [$];
  int   mptr = 0;
  logic [N-1:0]  exp_gnt = '0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  int            last_id = 0;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First requester at or after the model pointer, scanning circularly.
  function automatic int model_pick(input logic [N-1:0] req);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (mptr + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] req, input logic stall, input logic [N*AW-1:0] addrs);
    int k;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    bus.i_req   = req;
    bus.i_stall = stall;
    bus.i_addr  = addrs;
    exp_gnt     = '0;
    if (!stall && req != '0) begin
      k = model_pick(req);
      a = addrs[k*AW +: AW];
      exp_gnt[k] = 1'b1;
      iss_q.push_back('{addr: a, due: cyc + 1});
      rsp_q.push_back('{id: k, data: mem[a], due: cyc + 2 + RDL});
`ifndef RAM_ARB_FIXED_PRIO_EN
      mptr = (k + 1) % N;
`endif
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst_n       = 1'b0;
    bus.i_req   = '1;
    bus.i_stall = 1'b0;
    exp_gnt     = '0;
    rsp_q.delete();
    iss_q.delete();
    mptr      = 0;
    last_addr = '0;
    last_data = '0;
    last_id   = 0;
    @(negedge clk);
    chk("rst_gnt", bus.o_gnt, 0);
    chk("rst_rd_en", bus.o_ram_rd_en, 0);
    chk("rst_ram_addr", bus.o_ram_addr, 0);
    chk("rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("rst_rsp_id", bus.o_rsp_id, 0);
    chk("rst_rsp_data", bus.o_rsp_data, 0);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bus.i_req = '0;
  endtask

  // Monitor: compare grant, RAM issue and response against the queued expectations.
  rsp_t mr;
  iss_t mi;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt", bus.o_gnt, exp_gnt);
      while (iss_q.size() != 0 && iss_q[0].due < cyc) begin
        mi = iss_q.pop_front();
        chk("issue_missed", 0, 1);
      end
      if (iss_q.size() != 0 && iss_q[0].due == cyc) begin
        mi = iss_q.pop_front();
        chk("rd_en", bus.o_ram_rd_en, 1);
        chk("ram_addr", bus.o_ram_addr, mi.addr);
        last_addr = mi.addr;
      end else begin
        chk("rd_en_idle", bus.o_ram_rd_en, 0);
        chk("ram_addr_hold", bus.o_ram_addr, last_addr);
      end
      if (bus.o_rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", bus.o_rsp_valid, 0);
        end else begin
          mr = rsp_q.pop_front();
          chk("rsp_cycle", cyc, mr.due);
          chk("rsp_valid", bus.o_rsp_valid, 32'(1) << mr.id);
          chk("rsp_id", bus.o_rsp_id, mr.id);
          chk("rsp_data", bus.o_rsp_data, mr.data);
          last_data = mr.data;
          last_id   = mr.id;
        end
      end else begin
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
          mr = rsp_q.pop_front();
          chk("rsp_missing", 0, 1);
        end
        chk("rsp_data_hold", bus.o_rsp_data, last_data);
        chk("rsp_id_hold", bus.o_rsp_id, last_id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req   = '0;
    bus.i_stall = 1'b0;
    bus.i_addr  = '0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h12] = 8'hA5;
    mem[8'h34] = 8'h3C;

    do_reset(2);

    // Single read from requester 0
    drive(4'b0001, 1'b0, {8'h77, 8'h66, 8'h55, 8'h12});
    repeat (6) drive(4'b0000, 1'b0, $urandom);

    // All requesting continuously
    do_reset(1);
    repeat (10) drive(4'b1111, 1'b0, $urandom);
    repeat (6) drive(4'b0000, 1'b0, $urandom);

    // Pointer wrap: grant 2 leaves ptr=3, then 1001 gives 3 then 0, then ptr=1
    drive(4'b0100, 1'b0, $urandom);
    drive(4'b1001, 1'b0, $urandom);
    drive(4'b1001, 1'b0, $urandom);
    drive(4'b1111, 1'b0, $urandom);
    repeat (6) drive(4'b0000, 1'b0, $urandom);

    // Stall with a read already in flight
    drive(4'b0001, 1'b0, $urandom);
    repeat (3) drive(4'b0100, 1'b1, $urandom);
    drive(4'b0100, 1'b0, $urandom);
    repeat (6) drive(4'b0000, 1'b0, $urandom);

    // Reset two cycles after a grant drops the in-flight read
    drive(4'b0010, 1'b0, $urandom);
    drive(4'b0000, 1'b0, $urandom);
    do_reset(1);
    repeat (8) drive(4'b0000, 1'b0, $urandom);

    // Idle after a 0x3C response: data must hold while RAM output toggles
    drive(4'b0010, 1'b0, {8'h00, 8'h00, 8'h34, 8'h00});
    repeat (10) drive(4'b0000, 1'b0, $urandom);
    @(negedge clk);
    chk("idle_hold_3c", bus.o_rsp_data, 8'h3C);
    chk("idle_no_valid", bus.o_rsp_valid, 0);

    // Random traffic
    repeat (400) drive(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), $urandom);
    repeat (10) drive(4'b0000, 1'b0, $urandom);

    @(negedge clk);
    chk("drain_rsp_q", rsp_q.size(), 0);
    chk("drain_iss_q", iss_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
